// File: rtl/seg7_hex_encoder.sv
// seg7_hex_encoder
//   Recovers the 4-bit hex code from a sensed 7-segment glyph. Segment lines
//   are debounced with a stability counter, matched against the 16 standard
//   hex glyphs, and each newly stable glyph is emitted once on a valid/ready
//   handshake. Stable, non-blank patterns that are not hex glyphs raise a
//   one-cycle error pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   seg_in     segment lines {g,f,e,d,c,b,a}, bit0 = a, 1 = lit
//   out_ready  downstream accepts the nibble
//   out_valid  nibble valid (held until accepted)
//   nibble     decoded hex value
//   err        one-cycle pulse on a stable illegal pattern
//   glyph_cnt  count of accepted nibble transfers, wraps 255 -> 0
module seg7_hex_encoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] nibble,
    output logic       err,
    output logic [7:0] glyph_cnt
);

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned GCNT_W = 8;

    localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [SEG_W-1:0]  PAT_BLANK  = 7'h00;

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Glyph lookup: returns {legal, code}; blank and unknown patterns are not legal.
    function automatic logic [NIB_W:0] glyph_decode(input logic [SEG_W-1:0] pat);
        logic [NIB_W:0] res;
        res = {1'b0, 4'h0};
        case (pat)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    // Registered state
    state_t              state;
    logic [SEG_W-1:0]    seg_q;
    logic [CNT_W-1:0]    cnt;
    logic [SEG_W-1:0]    last_pat;

    // Next-state values
    state_t              state_n;
    logic [SEG_W-1:0]    last_pat_n;
    logic [CNT_W-1:0]    cnt_n;
    logic                out_valid_n;
    logic [NIB_W-1:0]    nibble_n;
    logic                err_n;
    logic [GCNT_W-1:0]   glyph_cnt_n;

    // Pattern classification of the debounced sample
    logic                stable_c;
    logic                blank_c;
    logic                legal_c;
    logic [NIB_W-1:0]    code_c;

    assign stable_c          = (cnt == STABLE_MAX);
    assign blank_c           = (seg_q == PAT_BLANK);
    assign {legal_c, code_c} = glyph_decode(seg_q);

    // Stability counter: restart on any change, saturate once stable.
    always_comb begin
        cnt_n = cnt;
        if (seg_in != seg_q) begin
            cnt_n = '0;
        end else if (cnt != STABLE_MAX) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n     = state;
        last_pat_n  = last_pat;
        out_valid_n = out_valid;
        nibble_n    = nibble;
        err_n       = 1'b0;
        glyph_cnt_n = glyph_cnt;

        case (state)
            ST_SCAN: begin
                if (stable_c) begin
                    if (blank_c) begin
                        last_pat_n = PAT_BLANK;
                    end else if (legal_c) begin
                        state_n     = ST_HOLD;
                        nibble_n    = code_c;
                        out_valid_n = 1'b1;
                        last_pat_n  = seg_q;
                    end else begin
                        state_n    = ST_DONE;
                        err_n      = 1'b1;
                        last_pat_n = seg_q;
                    end
                end
            end

            // Nibble frozen until the downstream side takes it.
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    glyph_cnt_n = glyph_cnt + GCNT_W'(1);
                    state_n     = ST_DONE;
                end
            end

            // Wait for a different stable pattern so a held glyph emits only once.
            ST_DONE: begin
                if (stable_c && (seg_q != last_pat)) begin
                    state_n = ST_SCAN;
                end
            end

            default: begin
                state_n     = ST_SCAN;
                out_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SCAN;
            seg_q     <= '0;
            cnt       <= '0;
            last_pat  <= '0;
            out_valid <= 1'b0;
            nibble    <= '0;
            err       <= 1'b0;
            glyph_cnt <= '0;
        end else begin
            state     <= state_n;
            seg_q     <= seg_in;
            cnt       <= cnt_n;
            last_pat  <= last_pat_n;
            out_valid <= out_valid_n;
            nibble    <= nibble_n;
            err       <= err_n;
            glyph_cnt <= glyph_cnt_n;
        end
    end

endmodule

// File: tb/tb_seg7_hex_encoder.sv
// Testbench for seg7_hex_encoder: directed glyph sequences checked against a
// history-based model every cycle, plus hand-computed latency/value checks.
module tb_seg7_hex_encoder;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] nibble;
    logic       err;
    logic [7:0] glyph_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_hex_encoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .nibble    (nibble),
        .err       (err),
        .glyph_cnt (glyph_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic int lut(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (glyphs[i] == p) return i;
        return -1;
    endfunction

    logic [6:0] hist[$];   // recent samples, oldest first; reset contributes one 00
    bit         m_pend, m_err, m_armed, m_st;
    logic [3:0] m_nib;
    logic [6:0] m_last, m_p;
    int         m_cnt, m_code;

    // Stable when the last S+1 samples are identical.
    function automatic bit model_stable();
        if (hist.size() < S + 1) return 1'b0;
        for (int i = 0; i <= int'(S); i++)
            if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            hist.push_back(7'h00);
            m_pend = 0; m_err = 0; m_armed = 1; m_nib = 0; m_last = 0; m_cnt = 0;
        end else begin
            m_st   = model_stable();
            m_p    = hist[hist.size() - 1];
            m_code = lut(m_p);
            m_err  = 0;
            if (m_pend) begin
                if (out_ready) begin
                    m_pend = 0; m_cnt = (m_cnt + 1) % 256; m_armed = 0;
                end
            end else if (!m_armed) begin
                if (m_st && m_p != m_last) m_armed = 1;
            end else if (m_st) begin
                if (m_p == 7'h00) m_last = 7'h00;
                else if (m_code >= 0) begin
                    m_pend = 1; m_nib = 4'(m_code); m_last = m_p;
                end else begin
                    m_err = 1; m_armed = 0; m_last = m_p;
                end
            end
            hist.push_back(seg_in);
            if (hist.size() > S + 1) void'(hist.pop_front());
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_out_valid", int'(out_valid), int'(m_pend));
            check("cyc_nibble",    int'(nibble),    int'(m_nib));
            check("cyc_err",       int'(err),       int'(m_err));
            check("cyc_glyph_cnt", int'(glyph_cnt), m_cnt);
            check("cyc_err_and_valid", int'(err & out_valid), 0);
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_valid(input int max_edges, output int edges);
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (!out_valid && edges < max_edges);
        if (!out_valid) check("wait_valid_timeout", 0, 1);
    endtask

    task automatic wait_err(input int max_edges, output int edges);
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (!err && edges < max_edges);
        if (!err) check("wait_err_timeout", 0, 1);
    endtask

    // Hold a pattern for n cycles, counting valid cycles and checking their nibble.
    task automatic run(input logic [6:0] pat, input int n, input int exp_nib, inout int vcount);
        seg_in = pat;
        repeat (n) begin
            @(negedge clk);
            if (out_valid) begin
                vcount++;
                check("run_nibble", int'(nibble), exp_nib);
            end
        end
    endtask

    int e, vc, ec;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // model pin checks
        check("lut_7C", lut(7'h7C), 11);
        check("lut_6F", lut(7'h6F), 9);
        check("lut_01", lut(7'h01), -1);

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_nibble",    int'(nibble),    0);
        check("rst_err",       int'(err),       0);
        check("rst_glyph_cnt", int'(glyph_cnt), 0);

        // Blank held: nothing happens.
        vc = 0; ec = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) vc++;
            if (err) ec++;
        end
        check("blank_valid_cycles", vc, 0);
        check("blank_err_cycles",   ec, 0);
        check("blank_glyph_cnt",    int'(glyph_cnt), 0);

        // 5B -> 2 after 6 edges, one-cycle valid, no re-emit while held.
        seg_in = 7'h5B; out_ready = 1'b1;
        wait_valid(20, e);
        check("t2_latency", e, 6);
        check("t2_nibble",  int'(nibble), 2);
        @(negedge clk);
        check("t2_valid_drop", int'(out_valid), 0);
        check("t2_glyph_cnt",  int'(glyph_cnt), 1);
        vc = 0;
        run(7'h5B, 50, 2, vc);
        check("t2_no_reemit", vc, 0);

        // 7C, blank, 7C -> two transfers of B.
        vc = 0;
        run(7'h7C, 10, 11, vc);
        run(7'h00, 10, 11, vc);
        run(7'h7C, 10, 11, vc);
        check("t3_transfers", vc, 2);
        check("t3_glyph_cnt", int'(glyph_cnt), 3);

        // Illegal 01 from SCAN: err after 6 edges, one cycle, no valid.
        vc = 0;
        run(7'h00, 10, 0, vc);
        seg_in = 7'h01;
        wait_err(20, e);
        check("t4_err_latency", e, 6);
        check("t4_err_no_valid", int'(out_valid), 0);
        @(negedge clk);
        check("t4_err_pulse_end", int'(err), 0);
        vc = 0;
        run(7'h01, 10, 0, vc);
        check("t4_no_valid", vc, 0);
        seg_in = 7'h06;
        wait_valid(20, e);
        check("t4_latency_from_done", e, 7);
        check("t4_nibble", int'(nibble), 1);
        @(negedge clk);
        check("t4_glyph_cnt", int'(glyph_cnt), 4);

        // 6F held in HOLD while input moves to 77.
        vc = 0;
        run(7'h00, 10, 0, vc);
        out_ready = 1'b0;
        seg_in = 7'h6F;
        wait_valid(20, e);
        check("t5_latency", e, 6);
        check("t5_nibble",  int'(nibble), 9);
        repeat (3) @(negedge clk);
        seg_in = 7'h77;
        repeat (12) @(negedge clk);
        check("t5_hold_valid",  int'(out_valid), 1);
        check("t5_hold_nibble", int'(nibble), 9);
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_xfer_drop", int'(out_valid), 0);
        wait_valid(10, e);
        check("t5_next_latency", e, 2);
        check("t5_next_nibble",  int'(nibble), 10);
        @(negedge clk);
        check("t5_glyph_cnt", int'(glyph_cnt), 6);

        // Glitch back to last pattern does not re-emit.
        vc = 0;
        run(7'h00, 10, 0, vc);
        seg_in = 7'h3F;
        wait_valid(20, e);
        check("t6_nibble", int'(nibble), 0);
        repeat (5) @(negedge clk);
        seg_in = 7'h7F;
        @(negedge clk);
        vc = 0;
        run(7'h3F, 20, 0, vc);
        check("t6_glitch_no_emit", vc, 0);
        check("t6_glyph_cnt", int'(glyph_cnt), 7);

        // Reset mid-HOLD.
        vc = 0;
        run(7'h00, 10, 0, vc);
        out_ready = 1'b0;
        seg_in = 7'h5B;
        wait_valid(20, e);
        check("t7_pre_rst_valid", int'(out_valid), 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_valid",     int'(out_valid), 0);
        check("t7_rst_nibble",    int'(nibble),    0);
        check("t7_rst_err",       int'(err),       0);
        check("t7_rst_glyph_cnt", int'(glyph_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        wait_valid(20, e);
        check("t7_after_rst_latency", e, 6);
        check("t7_after_rst_nibble",  int'(nibble), 2);
        @(negedge clk);
        check("t7_after_rst_glyph_cnt", int'(glyph_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
